// File: rtl/afifo_pkg.sv
// Shared defaults and types for the async FIFO read-side drain logic.
// No logic; constants and the 2-bit output-buffer level type only.
package afifo_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef logic [1:0] level_t;

    localparam level_t LVL_EMPTY = 2'd0;
    localparam level_t LVL_FULL  = 2'd2;
endpackage

// File: rtl/afifo_skid2.sv
// Two-entry in-order output buffer; head word and valid come straight from flops.
// Latency 1 cycle push-to-head; caller must not push at level 2, pop only while head valid.
module afifo_skid2
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_vld_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output level_t                level_o,
    output logic                  head_vld_o,
    output logic [DATA_WIDTH-1:0] head_dat_o
);
    level_t                level_q, level_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;

    always_comb begin
        level_d = level_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        unique case ({push_vld_i, pop_i})
            2'b10: begin
                if (level_q == LVL_EMPTY) begin
                    e0_d = push_dat_i;
                end else begin
                    e1_d = push_dat_i;
                end
                level_d = level_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                level_d = level_q - 2'd1;
            end
            2'b11: begin
                // At level 1 the incoming word replaces the departing head.
                if (level_q == LVL_FULL) begin
                    e0_d = e1_q;
                    e1_d = push_dat_i;
                end else begin
                    e0_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= LVL_EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            level_q <= level_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign level_o    = level_q;
    assign head_vld_o = (level_q != LVL_EMPTY);
    assign head_dat_o = e0_q;
endmodule

// File: rtl/afifo_rd_drain.sv
// Pops async-FIFO words into a 2-entry buffer and streams them out valid/ready, with debug counters.
// Latency 1 cycle rinc-to-m_valid; m_ready never reaches rinc, pops stop when the buffer holds 2.
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    logic                 run_q;
    logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    level_t               level;
    logic                 out_pop;

    // run holds pops off until the first edge after reset release.
    assign rinc    = run_q & en & ~rempty & (level != LVL_FULL);
    assign out_pop = m_valid & m_ready;

    afifo_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (rclk),
        .rst_n      (rrst_n),
        .push_vld_i (rinc),
        .push_dat_i (rdata),
        .pop_i      (out_pop),
        .level_o    (level),
        .head_vld_o (m_valid),
        .head_dat_o (m_data)
    );

    always_comb begin
        pop_count_d = pop_count_q;
        stall_cnt_d = stall_cnt_q;
        if (rinc) begin
            pop_count_d = pop_count_q + CNT_WIDTH'(1);
        end
        if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            run_q       <= 1'b0;
            pop_count_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            run_q       <= 1'b1;
            pop_count_q <= pop_count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign buf_level = level;
    assign pop_count = pop_count_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_afifo_rd_drain.sv
// Directed bench for afifo_rd_drain with a small FIFO read-port model; CNT_WIDTH=4 to reach counter limits.
module tb_afifo_rd_drain;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          en;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [1:0]    buf_level;
    logic [CW-1:0] pop_count;
    logic [CW-1:0] stall_cnt;

    // FIFO read-port model: bench writes mem/wr_ptr, pops advance rd_ptr on rinc edges.
    logic [DW-1:0] mem [64];
    logic [5:0]    wr_ptr = 6'd0;
    logic [5:0]    rd_ptr = 6'd0;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr];

    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 6'd1;

    always #5 rclk = ~rclk;

    afifo_rd_drain #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .en        (en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .buf_level (buf_level),
        .pop_count (pop_count),
        .stall_cnt (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          ld;
        logic [DW-1:0] ld_dat;
        logic          e_rinc;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic [1:0]    e_lvl;
        logic [CW-1:0] e_pop;
        logic [CW-1:0] e_stall;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic r, input logic l, input logic [DW-1:0] ld,
                       input logic xr, input logic xv, input logic [DW-1:0] xd,
                       input logic [1:0] xl, input logic [CW-1:0] xp, input logic [CW-1:0] xs);
        vec_t v;
        v.en = e; v.rdy = r; v.ld = l; v.ld_dat = ld;
        v.e_rinc = xr; v.e_vld = xv; v.e_dat = xd; v.e_lvl = xl; v.e_pop = xp; v.e_stall = xs;
        vq.push_back(v);
    endtask

    initial begin
        logic [DW-1:0] exp_w [8];
        int            idx;

        rrst_n  = 1'b0;
        en      = 1'b1;
        m_ready = 1'b0;

        // en, rdy, ld, ld_dat | rinc, vld, dat, lvl, pop, stall
        // en gating with words waiting, then 1 word/cycle streaming
        add(0, 1, 1, 32'h11, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 32'h22, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 32'h33, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0,      1, 0, 0,     0, 0, 0);
        add(1, 1, 0, 0,      1, 1, 32'h11, 1, 1, 0);
        add(1, 1, 0, 0,      1, 1, 32'h22, 1, 2, 0);
        add(1, 1, 0, 0,      0, 1, 32'h33, 1, 3, 0);
        add(1, 1, 0, 0,      0, 0, 0,     0, 3, 0);
        // backpressure: buffer fills to 2, head holds, stalls counted, then drain in order
        add(0, 0, 1, 32'h11, 0, 0, 0, 0, 3, 0);
        add(0, 0, 1, 32'h22, 0, 0, 0, 0, 3, 0);
        add(0, 0, 1, 32'h33, 0, 0, 0, 0, 3, 0);
        add(0, 0, 1, 32'h44, 0, 0, 0, 0, 3, 0);
        add(1, 0, 0, 0,      1, 0, 0,      0, 3, 0);
        add(1, 0, 0, 0,      1, 1, 32'h11, 1, 4, 0);
        add(1, 0, 0, 0,      0, 1, 32'h11, 2, 5, 1);
        add(1, 0, 0, 0,      0, 1, 32'h11, 2, 5, 2);
        add(1, 1, 0, 0,      0, 1, 32'h11, 2, 5, 3);
        add(1, 1, 0, 0,      1, 1, 32'h22, 1, 5, 3);
        add(1, 1, 0, 0,      1, 1, 32'h33, 1, 6, 3);
        add(1, 1, 0, 0,      0, 1, 32'h44, 1, 7, 3);
        add(1, 1, 0, 0,      0, 0, 0,      0, 7, 3);
        // en drop mid-stream, then rempty rising while a word is buffered
        add(0, 1, 1, 32'h55, 0, 0, 0, 0, 7, 3);
        add(0, 1, 1, 32'h66, 0, 0, 0, 0, 7, 3);
        add(1, 1, 0, 0,      1, 0, 0,      0, 7, 3);
        add(0, 1, 0, 0,      0, 1, 32'h55, 1, 8, 3);
        add(0, 1, 0, 0,      0, 0, 0,      0, 8, 3);
        add(1, 0, 0, 0,      1, 0, 0,      0, 8, 3);
        add(1, 0, 0, 0,      0, 1, 32'h66, 1, 9, 3);
        add(1, 1, 0, 0,      0, 1, 32'h66, 1, 9, 4);
        add(1, 1, 0, 0,      0, 0, 0,      0, 9, 4);

        #2;
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_data",    m_data,         32'd0);
        chk("rst_buf_level", 32'(buf_level), 32'd0);
        chk("rst_pop_count", 32'(pop_count), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_rinc",      32'(rinc),      32'd0);

        @(negedge rclk);
        rrst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            #1;
            chk("idle_rinc",      32'(rinc),      32'd0);
            chk("idle_m_valid",   32'(m_valid),   32'd0);
            chk("idle_buf_level", 32'(buf_level), 32'd0);
            chk("idle_pop_count", 32'(pop_count), 32'd0);
        end

        foreach (vq[i]) begin
            @(negedge rclk);
            en      = vq[i].en;
            m_ready = vq[i].rdy;
            if (vq[i].ld) load(vq[i].ld_dat);
            #1;
            chk($sformatf("v%0d_rinc", i),      32'(rinc),      32'(vq[i].e_rinc));
            chk($sformatf("v%0d_m_valid", i),   32'(m_valid),   32'(vq[i].e_vld));
            if (vq[i].e_vld) chk($sformatf("v%0d_m_data", i), m_data, vq[i].e_dat);
            chk($sformatf("v%0d_buf_level", i), 32'(buf_level), 32'(vq[i].e_lvl));
            chk($sformatf("v%0d_pop_count", i), 32'(pop_count), 32'(vq[i].e_pop));
            chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vq[i].e_stall));
        end

        // pop_count wrap: 9 + 8 pops = 17 -> 1 with a 4-bit counter; also check order
        @(negedge rclk);
        en      = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = 32'hA0 + 32'(i);
            load(exp_w[i]);
        end
        en  = 1'b1;
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            @(negedge rclk);
            #1;
            if (m_valid) begin
                chk($sformatf("wrap_word%0d", idx), m_data, exp_w[idx]);
                idx++;
            end
        end
        chk("wrap_words_delivered", 32'(idx), 32'd8);
        @(negedge rclk);
        #1;
        chk("wrap_pop_count", 32'(pop_count), 32'd1);
        chk("wrap_buf_level", 32'(buf_level), 32'd0);

        // stall_cnt saturation at 15 and hold
        m_ready = 1'b0;
        load(32'hBB);
        repeat (25) @(negedge rclk);
        #1;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_m_data",    m_data,         32'hBB);
        chk("sat_buf_level", 32'(buf_level), 32'd1);
        @(negedge rclk);
        #1;
        chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
        m_ready = 1'b1;
        @(negedge rclk);
        #1;
        chk("sat_drained_level", 32'(buf_level), 32'd0);
        chk("sat_pop_count",     32'(pop_count), 32'd2);

        // asynchronous reset with the buffer full; FIFO keeps its last word
        m_ready = 1'b0;
        en      = 1'b0;
        load(32'hC1);
        load(32'hC2);
        load(32'hC3);
        en = 1'b1;
        repeat (3) @(negedge rclk);
        #1;
        chk("prerst_buf_level", 32'(buf_level), 32'd2);
        chk("prerst_rinc",      32'(rinc),      32'd0);
        chk("prerst_m_data",    m_data,         32'hC1);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("arst_m_valid",   32'(m_valid),   32'd0);
        chk("arst_buf_level", 32'(buf_level), 32'd0);
        chk("arst_rinc",      32'(rinc),      32'd0);
        chk("arst_pop_count", 32'(pop_count), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        #1;
        chk("rel_rinc_blocked", 32'(rinc), 32'd0);
        @(negedge rclk);
        #1;
        chk("rel_rinc_run",    32'(rinc),    32'd1);
        chk("rel_m_valid",     32'(m_valid), 32'd0);
        @(negedge rclk);
        #1;
        chk("rel_m_valid_after", 32'(m_valid),   32'd1);
        chk("rel_m_data",        m_data,         32'hC3);
        chk("rel_pop_count",     32'(pop_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
